// File: rtl/rv32_lsu.sv
// Load/store unit for the pito RV32 core: accepts one decoded memory op at a time, steers
// byte lanes toward data memory and sign/zero-extends load data on the way back.
module rv32_lsu #(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned DMEM_AW = 12,
    parameter int unsigned HART_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_opcode,
    input  logic [XPR_LEN-1:0] in_addr,
    input  logic [XPR_LEN-1:0] in_wdata,
    input  logic [4:0]         in_rd,
    input  logic [HART_W-1:0]  in_hart,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [XPR_LEN-1:0] dmem_wdata,
    input  logic [XPR_LEN-1:0] dmem_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [HART_W-1:0]  wb_hart,
    output logic [XPR_LEN-1:0] wb_data,
    output logic               exc_valid,
    output logic [31:0]        exc_cause,
    output logic [HART_W-1:0]  exc_hart,
    output logic [XPR_LEN-1:0] exc_tval
);
    localparam logic [5:0] OpLb  = 6'd0;
    localparam logic [5:0] OpLh  = 6'd1;
    localparam logic [5:0] OpLw  = 6'd2;
    localparam logic [5:0] OpLbu = 6'd3;
    localparam logic [5:0] OpLhu = 6'd4;
    localparam logic [5:0] OpSb  = 6'd5;
    localparam logic [5:0] OpSh  = 6'd6;
    localparam logic [5:0] OpSw  = 6'd7;

    localparam logic [31:0] CauseIllegal    = 32'd2;
    localparam logic [31:0] CauseLdMisalign = 32'd4;
    localparam logic [31:0] CauseLdFault    = 32'd5;
    localparam logic [31:0] CauseStMisalign = 32'd6;
    localparam logic [31:0] CauseStFault    = 32'd7;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [1:0]         off_q, off_d;
    logic [4:0]         rd_q, rd_d;
    logic [HART_W-1:0]  hart_q, hart_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [XPR_LEN-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               wb_valid_q, wb_valid_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [HART_W-1:0]  wb_hart_q, wb_hart_d;
    logic [XPR_LEN-1:0] wb_data_q, wb_data_d;
    logic               exc_valid_q, exc_valid_d;
    logic [31:0]        exc_cause_q, exc_cause_d;
    logic [HART_W-1:0]  exc_hart_q, exc_hart_d;
    logic [XPR_LEN-1:0] exc_tval_q, exc_tval_d;

    logic               accept, active;
    logic               is_byte, is_half, is_word, is_store, is_illegal;
    logic               misaligned, out_of_range;
    logic [3:0]         req_be;
    logic [XPR_LEN-1:0] req_wdata, lane, load_data;

    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;
    assign active   = (state_q != StIdle);

    always_comb begin
        is_byte      = (in_opcode == OpLb) || (in_opcode == OpLbu) || (in_opcode == OpSb);
        is_half      = (in_opcode == OpLh) || (in_opcode == OpLhu) || (in_opcode == OpSh);
        is_word      = (in_opcode == OpLw) || (in_opcode == OpSw);
        is_store     = (in_opcode == OpSb) || (in_opcode == OpSh) || (in_opcode == OpSw);
        is_illegal   = !(is_byte || is_half || is_word);
        misaligned   = (is_half && in_addr[0]) || (is_word && (in_addr[1:0] != 2'b00));
        out_of_range = (in_addr[XPR_LEN-1:DMEM_AW+2] != '0);
        if (is_byte) begin
            req_be    = 4'b0001 << in_addr[1:0];
            req_wdata = {4{in_wdata[7:0]}};
        end else if (is_half) begin
            req_be    = 4'b0011 << {in_addr[1], 1'b0};
            req_wdata = {2{in_wdata[15:0]}};
        end else begin
            req_be    = 4'b1111;
            req_wdata = in_wdata;
        end
    end

    // Shift the addressed lane down to bit 0, then extend by load type.
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        unique case (op_q)
            OpLb:    load_data = {{(XPR_LEN-8){lane[7]}}, lane[7:0]};
            OpLh:    load_data = {{(XPR_LEN-16){lane[15]}}, lane[15:0]};
            OpLbu:   load_data = {{(XPR_LEN-8){1'b0}}, lane[7:0]};
            OpLhu:   load_data = {{(XPR_LEN-16){1'b0}}, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        hart_d      = hart_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_hart_d   = wb_hart_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_hart_d  = exc_hart_q;
        exc_tval_d  = exc_tval_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_illegal) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CauseIllegal;
                        exc_hart_d  = in_hart;
                        exc_tval_d  = '0;
                    end else if (misaligned) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = is_store ? CauseStMisalign : CauseLdMisalign;
                        exc_hart_d  = in_hart;
                        exc_tval_d  = in_addr;
                    end else if (out_of_range) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = is_store ? CauseStFault : CauseLdFault;
                        exc_hart_d  = in_hart;
                        exc_tval_d  = in_addr;
                    end else begin
                        state_d = StIssue;
                        op_d    = in_opcode;
                        off_d   = in_addr[1:0];
                        rd_d    = in_rd;
                        hart_d  = in_hart;
                        addr_d  = in_addr[DMEM_AW+1:2];
                        be_d    = req_be;
                        wdata_d = req_wdata;
                        we_d    = is_store;
                    end
                end
            end
            StIssue: state_d = we_q ? StIdle : StWait;
            StWait: begin
                state_d    = StIdle;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_hart_d  = hart_q;
                wb_data_d  = load_data;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            hart_q      <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_hart_q   <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_hart_q  <= '0;
            exc_tval_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            hart_q      <= hart_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_hart_q   <= wb_hart_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_hart_q  <= exc_hart_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    // Memory-side fields read as zero whenever no operation is in flight.
    assign dmem_req   = (state_q == StIssue);
    assign dmem_we    = active && we_q;
    assign dmem_addr  = active ? addr_q : '0;
    assign dmem_be    = active ? be_q : '0;
    assign dmem_wdata = active ? wdata_q : '0;

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_hart   = wb_hart_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_hart  = exc_hart_q;
    assign exc_tval  = exc_tval_q;

endmodule
